traffic_conflict_monitor: RTL and testbench
===========================================

Name: traffic_conflict_monitor

Overview:
- Downstream safety stage between the traffic-light controller FSM and the lamp drivers.
- Samples the six NS/EW lamp commands each cycle and checks three things: no conflicting greens, one-hot lamps per direction, and a legal per-direction sequence with minimum yellow time and a stuck-controller watchdog.
- With no fault, it passes lamps through with one cycle of latency.
- On any fault, it latches the fault and drives both directions to flashing red until cleared.

Parameters:
- MIN_YELLOW, 3, minimum consecutive cycles yellow must be sampled before a Y->R transition is legal.
- MAX_DWELL, 16, maximum consecutive cycles the full 6-bit lamp vector may stay unchanged.
- FLASH_PERIOD, 4, cycles per on or off half-phase of the fault flash.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ns_r_in, ns_y_in, ns_g_in  in  1 each  NS lamp commands from the controller
- ew_r_in, ew_y_in, ew_g_in  in  1 each  EW lamp commands from the controller
- fault_clr  in  1  single-cycle request to leave FAULT
- ns_r, ns_y, ns_g, ew_r, ew_y, ew_g  out  1 each  registered lamp drive outputs
- fault  out  1  high while in FAULT
- fault_code  out  3  latched cause of the fault; 0 = none

Behaviour:
- Reset is synchronous active-high rst, clock clk. On reset:
  - state = ARM
  - ns_r = ew_r = 1; all yellow/green outputs = 0
  - fault = 0, fault_code = 0
  - all counters = 0
- States: ARM, RUN, FAULT.
- ARM (one cycle):
  - Outputs are steady red on both directions.
  - Samples the inputs into prev_vec and sets dwell_cnt = 1, and each yellow counter to 1 if that yellow is set, else 0.
  - Runs only the static checks (codes 1-3). A static fault goes to FAULT; otherwise go to RUN.
- RUN: each cycle the inputs are checked against prev_vec. If no fault, outputs = inputs on the next edge (1-cycle latency). Fault codes:
  - 1 conflict: ns_r_in = 0 and ew_r_in = 0 at the same time.
  - 2 NS not one-hot: NS inputs are not exactly one of R/Y/G.
  - 3 EW not one-hot: EW inputs are not exactly one of R/Y/G.
  - 4 illegal transition in either direction. Legal transitions are hold, G->Y, Y->R and R->G; G->R, Y->G and R->Y are illegal. Checked only when both previous and current samples for that direction are one-hot.
  - 5 short yellow: Y->R transition while that direction's yellow counter is < MIN_YELLOW. The yellow counter is the number of consecutive yellow samples; it saturates at MIN_YELLOW and clears when yellow drops.
  - 6 watchdog: the input vector equals prev_vec and dwell_cnt == MAX_DWELL, i.e. the vector is unchanged for MAX_DWELL+1 consecutive samples. dwell_cnt resets to 1 on any change and saturates at MAX_DWELL.
- Simultaneous causes: the lowest code wins. The fault is detected in the same cycle the bad vector is sampled.
- Entering FAULT:
  - fault = 1 and fault_code is latched on the next edge.
  - On that same edge, outputs go to flash-on: ns_r = ew_r = 1, all Y/G = 0.
  - The bad vector is never driven to the outputs.
- FAULT:
  - All Y/G outputs = 0.
  - ns_r = ew_r = flash phase: 1 for FLASH_PERIOD cycles, then 0 for FLASH_PERIOD cycles, repeating. The flash counter restarts at every FAULT entry.
  - fault_code holds; input faults are ignored.
- fault_clr:
  - In FAULT, if the current inputs pass codes 1-3: go to ARM on the next edge, fault = 0, fault_code = 0, outputs steady red.
  - In FAULT with inputs that fail codes 1-3: fault_clr is ignored.
  - Ignored in ARM and RUN.
- rst in any state, including mid-flash, returns to the reset values on the next edge.
- Counter widths: ceil(log2(MAX_DWELL+1)), ceil(log2(MIN_YELLOW+1)) and ceil(log2(FLASH_PERIOD)) bits; no wrap-around (counters saturate or reset as specified).

Test Plan:
- Legal cycle: NS G 11 cycles, NS Y 4, EW G 11, EW Y 4, repeated 3 times -> outputs equal inputs delayed 1 cycle, fault stays 0, fault_code = 0.
- Conflict: in RUN drive ns_g_in = 1 and ew_g_in = 1 (both reds 0) for one cycle -> next edge fault = 1, fault_code = 1, ns_r = ew_r = 1 for 4 cycles, 0 for 4, repeating; no green ever reaches the outputs.
- Short yellow: NS Y for 2 cycles, then NS R with EW G -> fault_code = 5. Same stimulus with NS Y for 3 cycles -> no fault.
- Illegal transition and priority: NS G->R directly while EW stays R -> code 4. Apply NS = 3'b000 together with an EW illegal jump -> code 2.
- Watchdog: hold the NS G/EW R vector 16 cycles -> no fault; hold it 17 cycles -> fault_code = 6 on the edge after sample 17.
- Clear and reset: in FAULT pulse fault_clr with both-green inputs -> stays FAULT. Pulse it with NS R/EW G inputs -> ARM for 1 cycle (both red), then RUN. Assert rst mid-flash -> next edge fault = 0, code = 0, steady both-red.

Source files
------------

// File: rtl/traffic_conflict_monitor_if.sv
// Lamp-command bus between the traffic-light controller and the conflict monitor.
// The master drives the commands and fault_clr; the slave (the monitor) drives the lamp outputs and fault status.
interface traffic_conflict_monitor_if;
  logic       ns_r_in;
  logic       ns_y_in;
  logic       ns_g_in;
  logic       ew_r_in;
  logic       ew_y_in;
  logic       ew_g_in;
  logic       fault_clr;
  logic       ns_r;
  logic       ns_y;
  logic       ns_g;
  logic       ew_r;
  logic       ew_y;
  logic       ew_g;
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output ns_r_in, ns_y_in, ns_g_in, ew_r_in, ew_y_in, ew_g_in, fault_clr,
    input  ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, fault, fault_code
  );

  modport slave (
    input  ns_r_in, ns_y_in, ns_g_in, ew_r_in, ew_y_in, ew_g_in, fault_clr,
    output ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, fault, fault_code
  );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor between the traffic-light controller and the lamp drivers.
// It passes lamps through with one cycle of latency, and on any fault it latches the cause and flashes red.
module traffic_conflict_monitor #(
  parameter int unsigned MIN_YELLOW   = 3,
  parameter int unsigned MAX_DWELL    = 16,
  parameter int unsigned FLASH_PERIOD = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  traffic_conflict_monitor_if.slave   bus
);

  localparam int unsigned DW = $clog2(MAX_DWELL + 1);
  localparam int unsigned YW = $clog2(MIN_YELLOW + 1);
  localparam int unsigned FW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

  localparam logic [DW-1:0] DWELL_MAX  = DW'(MAX_DWELL);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1'b1);
  localparam logic [YW-1:0] YEL_MIN    = YW'(MIN_YELLOW);
  localparam logic [YW-1:0] YEL_ONE    = YW'(1'b1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_PERIOD - 1);
  localparam logic [FW-1:0] FLASH_ONE  = FW'(1'b1);
  localparam logic [5:0]    ALL_RED    = 6'b100_100;
  localparam logic [5:0]    ALL_DARK   = 6'b000_000;

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_CONFLICT = 3'd1;
  localparam logic [2:0] CODE_NS_OH    = 3'd2;
  localparam logic [2:0] CODE_EW_OH    = 3'd3;
  localparam logic [2:0] CODE_ILLEGAL  = 3'd4;
  localparam logic [2:0] CODE_SHORT_Y  = 3'd5;
  localparam logic [2:0] CODE_WATCHDOG = 3'd6;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Direction triples are {r, y, g}.
  function automatic logic one_hot3(input logic [2:0] v);
    return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction

  // G->R, Y->G and R->Y are the only illegal changes between one-hot samples.
  function automatic logic bad_step(input logic [2:0] p, input logic [2:0] c);
    return (p[0] && c[2]) || (p[1] && c[0]) || (p[2] && c[1]);
  endfunction

  function automatic logic [YW-1:0] ycnt_next(input logic [YW-1:0] cnt, input logic yel);
    if (!yel) begin
      return '0;
    end else if (cnt == YEL_MIN) begin
      return cnt;
    end else begin
      return cnt + YEL_ONE;
    end
  endfunction

  state_t        state_q, state_d;
  logic [5:0]    prev_vec_q, prev_vec_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [YW-1:0] ns_ycnt_q, ns_ycnt_d;
  logic [YW-1:0] ew_ycnt_q, ew_ycnt_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic [5:0]    out_q, out_d;
  logic          fault_q, fault_d;
  logic [2:0]    code_q, code_d;

  logic [5:0]    in_vec_s;
  logic [2:0]    ns_in_s, ew_in_s, ns_prev_s, ew_prev_s;
  logic [2:0]    static_code_s, run_code_s;
  logic          illegal_s, short_y_s, watchdog_s;

  assign in_vec_s  = {bus.ns_r_in, bus.ns_y_in, bus.ns_g_in, bus.ew_r_in, bus.ew_y_in, bus.ew_g_in};
  assign ns_in_s   = in_vec_s[5:3];
  assign ew_in_s   = in_vec_s[2:0];
  assign ns_prev_s = prev_vec_q[5:3];
  assign ew_prev_s = prev_vec_q[2:0];

  assign illegal_s = (one_hot3(ns_prev_s) && one_hot3(ns_in_s) && bad_step(ns_prev_s, ns_in_s)) ||
                     (one_hot3(ew_prev_s) && one_hot3(ew_in_s) && bad_step(ew_prev_s, ew_in_s));
  assign short_y_s = (ns_prev_s[1] && ns_in_s[2] && (ns_ycnt_q < YEL_MIN)) ||
                     (ew_prev_s[1] && ew_in_s[2] && (ew_ycnt_q < YEL_MIN));
  assign watchdog_s = (in_vec_s == prev_vec_q) && (dwell_q == DWELL_MAX);

  // Fault classification; lower codes take priority.
  always_comb begin
    static_code_s = CODE_NONE;
    run_code_s    = CODE_NONE;
    if (!ns_in_s[2] && !ew_in_s[2]) begin
      static_code_s = CODE_CONFLICT;
    end else if (!one_hot3(ns_in_s)) begin
      static_code_s = CODE_NS_OH;
    end else if (!one_hot3(ew_in_s)) begin
      static_code_s = CODE_EW_OH;
    end else begin
      static_code_s = CODE_NONE;
    end
    if (static_code_s != CODE_NONE) begin
      run_code_s = static_code_s;
    end else if (illegal_s) begin
      run_code_s = CODE_ILLEGAL;
    end else if (short_y_s) begin
      run_code_s = CODE_SHORT_Y;
    end else if (watchdog_s) begin
      run_code_s = CODE_WATCHDOG;
    end else begin
      run_code_s = CODE_NONE;
    end
  end

  // Next-state and next-output logic for the ARM/RUN/FAULT sequence.
  always_comb begin
    state_d     = state_q;
    prev_vec_d  = prev_vec_q;
    dwell_d     = dwell_q;
    ns_ycnt_d   = ns_ycnt_q;
    ew_ycnt_d   = ew_ycnt_q;
    flash_cnt_d = flash_cnt_q;
    out_d       = out_q;
    fault_d     = fault_q;
    code_d      = code_q;
    case (state_q)
      ST_ARM: begin
        prev_vec_d = in_vec_s;
        dwell_d    = DWELL_ONE;
        ns_ycnt_d  = ns_in_s[1] ? YEL_ONE : '0;
        ew_ycnt_d  = ew_in_s[1] ? YEL_ONE : '0;
        out_d      = ALL_RED;
        if (static_code_s != CODE_NONE) begin
          state_d     = ST_FAULT;
          fault_d     = 1'b1;
          code_d      = static_code_s;
          flash_cnt_d = '0;
        end else begin
          state_d = ST_RUN;
          fault_d = 1'b0;
          code_d  = CODE_NONE;
        end
      end
      ST_RUN: begin
        if (run_code_s != CODE_NONE) begin
          state_d     = ST_FAULT;
          fault_d     = 1'b1;
          code_d      = run_code_s;
          flash_cnt_d = '0;
          out_d       = ALL_RED;
        end else begin
          prev_vec_d = in_vec_s;
          if (in_vec_s == prev_vec_q) begin
            dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : (dwell_q + DWELL_ONE);
          end else begin
            dwell_d = DWELL_ONE;
          end
          ns_ycnt_d = ycnt_next(ns_ycnt_q, ns_in_s[1]);
          ew_ycnt_d = ycnt_next(ew_ycnt_q, ew_in_s[1]);
          out_d     = in_vec_s;
        end
      end
      ST_FAULT: begin
        if (bus.fault_clr && (static_code_s == CODE_NONE)) begin
          state_d = ST_ARM;
          fault_d = 1'b0;
          code_d  = CODE_NONE;
          out_d   = ALL_RED;
        end else if (flash_cnt_q == FLASH_LAST) begin
          flash_cnt_d = '0;
          out_d       = out_q[5] ? ALL_DARK : ALL_RED;
        end else begin
          flash_cnt_d = flash_cnt_q + FLASH_ONE;
          out_d       = out_q;
        end
      end
      default: begin
        state_d = ST_ARM;
        out_d   = ALL_RED;
        fault_d = 1'b0;
        code_d  = CODE_NONE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARM;
      prev_vec_q  <= 6'b000_000;
      dwell_q     <= '0;
      ns_ycnt_q   <= '0;
      ew_ycnt_q   <= '0;
      flash_cnt_q <= '0;
      out_q       <= ALL_RED;
      fault_q     <= 1'b0;
      code_q      <= CODE_NONE;
    end else begin
      state_q     <= state_d;
      prev_vec_q  <= prev_vec_d;
      dwell_q     <= dwell_d;
      ns_ycnt_q   <= ns_ycnt_d;
      ew_ycnt_q   <= ew_ycnt_d;
      flash_cnt_q <= flash_cnt_d;
      out_q       <= out_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
    end
  end

  assign bus.ns_r       = out_q[5];
  assign bus.ns_y       = out_q[4];
  assign bus.ns_g       = out_q[3];
  assign bus.ew_r       = out_q[2];
  assign bus.ew_y       = out_q[1];
  assign bus.ew_g       = out_q[0];
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor: a table of per-cycle vectors plus
// hand-written sequences for the legal cycle, watchdog, flash pattern and reset.
module tb_traffic_conflict_monitor;

  localparam logic [5:0] RR = 6'b100_100;
  localparam logic [5:0] GR = 6'b001_100;
  localparam logic [5:0] YR = 6'b010_100;
  localparam logic [5:0] RG = 6'b100_001;
  localparam logic [5:0] RY = 6'b100_010;
  localparam logic [5:0] GG = 6'b001_001;
  localparam logic [5:0] DK = 6'b000_000;

  typedef struct {
    logic       rst;
    logic       clr;
    logic [5:0] vec;
    logic [5:0] exp_out;
    logic       exp_f;
    logic [2:0] exp_c;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  traffic_conflict_monitor_if bus();

  traffic_conflict_monitor #(
    .MIN_YELLOW  (3),
    .MAX_DWELL   (16),
    .FLASH_PERIOD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic add(input logic r, input logic c, input logic [5:0] v,
                     input logic [5:0] eo, input logic ef, input logic [2:0] ec);
    vec_t e;
    e.rst = r; e.clr = c; e.vec = v; e.exp_out = eo; e.exp_f = ef; e.exp_c = ec;
    tbl.push_back(e);
  endtask

  // Drive one cycle of inputs, clock it, then compare the registered outputs.
  task automatic step(input logic r, input logic c, input logic [5:0] v,
                      input logic [5:0] eo, input logic ef, input logic [2:0] ec, input string nm);
    logic [5:0] act;
    rst = r;
    bus.fault_clr = c;
    {bus.ns_r_in, bus.ns_y_in, bus.ns_g_in, bus.ew_r_in, bus.ew_y_in, bus.ew_g_in} = v;
    @(posedge clk);
    #1;
    act = {bus.ns_r, bus.ns_y, bus.ns_g, bus.ew_r, bus.ew_y, bus.ew_g};
    total++;
    if (act !== eo || bus.fault !== ef || bus.fault_code !== ec) begin
      bad++;
      $display("FAIL %s: got out=%b fault=%b code=%0d, want out=%b fault=%b code=%0d",
               nm, act, bus.fault, bus.fault_code, eo, ef, ec);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.fault_clr = 1'b0;
    {bus.ns_r_in, bus.ns_y_in, bus.ns_g_in, bus.ew_r_in, bus.ew_y_in, bus.ew_g_in} = RR;

    add(1'b1, 1'b0, RR, RR, 1'b0, 3'd0);  // 0 reset
    add(1'b0, 1'b0, RR, RR, 1'b0, 3'd0);  // 1 ARM -> RUN, steady red
    add(1'b0, 1'b0, RR, RR, 1'b0, 3'd0);  // 2 pass-through
    add(1'b0, 1'b0, GR, GR, 1'b0, 3'd0);  // 3
    add(1'b0, 1'b0, YR, YR, 1'b0, 3'd0);  // 4
    add(1'b0, 1'b0, YR, YR, 1'b0, 3'd0);  // 5
    add(1'b0, 1'b0, RG, RR, 1'b1, 3'd5);  // 6 NS yellow only 2 cycles
    add(1'b0, 1'b1, GG, RR, 1'b1, 3'd5);  // 7 clear refused with conflicting inputs
    add(1'b0, 1'b1, RG, RR, 1'b0, 3'd0);  // 8 clear accepted -> ARM
    add(1'b0, 1'b0, RG, RR, 1'b0, 3'd0);  // 9 ARM cycle stays red
    add(1'b0, 1'b0, RG, RG, 1'b0, 3'd0);  // 10 RUN
    add(1'b0, 1'b0, RY, RY, 1'b0, 3'd0);  // 11
    add(1'b0, 1'b0, RY, RY, 1'b0, 3'd0);  // 12
    add(1'b0, 1'b0, RY, RY, 1'b0, 3'd0);  // 13
    add(1'b0, 1'b0, GR, GR, 1'b0, 3'd0);  // 14 EW yellow exactly 3 cycles
    add(1'b0, 1'b0, YR, YR, 1'b0, 3'd0);  // 15
    add(1'b0, 1'b0, YR, YR, 1'b0, 3'd0);  // 16
    add(1'b0, 1'b0, YR, YR, 1'b0, 3'd0);  // 17
    add(1'b0, 1'b0, RG, RG, 1'b0, 3'd0);  // 18 NS yellow exactly 3 cycles
    add(1'b0, 1'b0, RY, RY, 1'b0, 3'd0);  // 19
    add(1'b0, 1'b0, RY, RY, 1'b0, 3'd0);  // 20
    add(1'b0, 1'b0, RY, RY, 1'b0, 3'd0);  // 21
    add(1'b0, 1'b0, GR, GR, 1'b0, 3'd0);  // 22
    add(1'b0, 1'b0, RR, RR, 1'b1, 3'd4);  // 23 NS G->R
    add(1'b0, 1'b0, RR, RR, 1'b1, 3'd4);  // 24 flash on
    add(1'b0, 1'b0, GG, RR, 1'b1, 3'd4);  // 25 input faults ignored
    add(1'b0, 1'b0, GG, RR, 1'b1, 3'd4);  // 26
    add(1'b0, 1'b0, GG, DK, 1'b1, 3'd4);  // 27 flash off phase
    add(1'b0, 1'b1, RR, RR, 1'b0, 3'd0);  // 28 clear -> ARM
    add(1'b0, 1'b0, RR, RR, 1'b0, 3'd0);  // 29 ARM -> RUN
    add(1'b0, 1'b0, RG, RG, 1'b0, 3'd0);  // 30
    add(1'b0, 1'b0, 6'b000_100, RR, 1'b1, 3'd2);  // 31 NS dark beats EW G->R
    add(1'b0, 1'b1, RR, RR, 1'b0, 3'd0);  // 32 clear -> ARM
    add(1'b0, 1'b0, 6'b100_110, RR, 1'b1, 3'd3);  // 33 static fault caught in ARM
    add(1'b0, 1'b1, RR, RR, 1'b0, 3'd0);  // 34 clear -> ARM
    add(1'b0, 1'b0, RR, RR, 1'b0, 3'd0);  // 35 ARM -> RUN
    add(1'b0, 1'b1, GR, GR, 1'b0, 3'd0);  // 36 fault_clr ignored in RUN

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].clr, tbl[i].vec, tbl[i].exp_out, tbl[i].exp_f, tbl[i].exp_c,
           $sformatf("table[%0d]", i));
    end

    // Full legal cycle three times; outputs follow inputs one edge later.
    for (int rep = 0; rep < 3; rep++) begin
      for (int n = 0; n < 11; n++) step(1'b0, 1'b0, GR, GR, 1'b0, 3'd0, $sformatf("legal r%0d nsg%0d", rep, n));
      for (int n = 0; n < 4; n++)  step(1'b0, 1'b0, YR, YR, 1'b0, 3'd0, $sformatf("legal r%0d nsy%0d", rep, n));
      for (int n = 0; n < 11; n++) step(1'b0, 1'b0, RG, RG, 1'b0, 3'd0, $sformatf("legal r%0d ewg%0d", rep, n));
      for (int n = 0; n < 4; n++)  step(1'b0, 1'b0, RY, RY, 1'b0, 3'd0, $sformatf("legal r%0d ewy%0d", rep, n));
    end

    // Watchdog: 16 identical samples are fine, the 17th trips it.
    for (int n = 1; n <= 16; n++) step(1'b0, 1'b0, GR, GR, 1'b0, 3'd0, $sformatf("dwell %0d", n));
    step(1'b0, 1'b0, GR, RR, 1'b1, 3'd6, "watchdog trip");

    // Flash pattern: 4 on, 4 off, counted from the entry edge.
    for (int k = 1; k <= 13; k++) begin
      step(1'b0, 1'b0, GG, (((k / 4) % 2) == 0) ? RR : DK, 1'b1, 3'd6, $sformatf("flash6 k%0d", k));
    end
    step(1'b1, 1'b0, GG, RR, 1'b0, 3'd0, "reset mid-flash");

    // Conflict: both greens never reach the lamps.
    step(1'b0, 1'b0, RR, RR, 1'b0, 3'd0, "post-reset ARM");
    step(1'b0, 1'b0, GR, GR, 1'b0, 3'd0, "pre-conflict");
    step(1'b0, 1'b0, GG, RR, 1'b1, 3'd1, "conflict");
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b0, GG, (((k / 4) % 2) == 0) ? RR : DK, 1'b1, 3'd1, $sformatf("flash1 k%0d", k));
    end
    step(1'b0, 1'b1, RG, RR, 1'b0, 3'd0, "clear to ARM");
    step(1'b0, 1'b0, RG, RR, 1'b0, 3'd0, "ARM red");
    step(1'b0, 1'b0, RG, RG, 1'b0, 3'd0, "RUN again");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
